// File: rtl/spi_buffer_tx.sv
// spi_buffer_tx: streams bytes out of the read port of a block RAM buffer as an
// SPI mode-0 master transmitter (CPOL=0, CPHA=0), MSB first.
//
// The first byte is fetched and loaded before SCK starts. Every later byte is
// prefetched into a hold register while the current byte shifts, so SCK keeps
// a constant period across byte boundaries.
//
// Optional feature, enabled by defining SPI_TX_CRC16_EN: adds the AppendCrc
// input and a CRC16-CCITT (poly 0x1021, init 0) over the payload bits. The CRC
// is sent MSB first directly after the payload when AppendCrc was set at Start.
//
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   Start             one-cycle request, accepted only when idle
//   StartAddr, Length first address and byte count (0 = 2^ADDR_W), latched at Start
//   ClkDiv            SCK half-period minus one, in Clk cycles, latched at Start
//   AppendCrc         (SPI_TX_CRC16_EN only) append CRC16 after the payload
//   Busy, Done        transfer in progress / one-cycle end pulse
//   BufReadEnable     buffer read strobe; data returns one cycle later
//   BufReadAddr       buffer read address
//   BufReadData       buffer read data
//   SpiSck, SpiMosi   SPI clock (idle low) and data out (idle high)
module spi_buffer_tx #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] Length,
  input  logic [DIV_W-1:0]  ClkDiv,
`ifdef SPI_TX_CRC16_EN
  input  logic              AppendCrc,
`endif
  output logic              Busy,
  output logic              Done,
  output logic              BufReadEnable,
  output logic [ADDR_W-1:0] BufReadAddr,
  input  logic [7:0]        BufReadData,
  output logic              SpiSck,
  output logic              SpiMosi
);

  localparam int unsigned     CntW      = ADDR_W + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(1) << ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StShift,
    StCrc,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ren_q, ren_d;
  logic              ren_dly_q;
  logic [7:0]        hold_q;
  // Bytes still to be loaded into the shifter after the one currently shifting.
  logic [CntW-1:0]   rem_q, rem_d;
  logic [DIV_W-1:0]  div_lat_q, div_lat_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  // Bits of the current byte not yet on MOSI; MOSI itself holds the bit on the line.
  logic [6:0]        shift_q, shift_d;
  logic [3:0]        bit_q, bit_d;
  // One closing cycle with SCK low after the final bit, before DONE.
  logic              tail_q, tail_d;
`ifdef SPI_TX_CRC16_EN
  logic [15:0]       crc_q, crc_d;
  logic              crc_en_q, crc_en_d;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ren_d     = 1'b0;
    rem_d     = rem_q;
    div_lat_d = div_lat_q;
    div_d     = div_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    tail_d    = tail_q;
`ifdef SPI_TX_CRC16_EN
    crc_d     = crc_q;
    crc_en_d  = crc_en_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d   = StFetch;
          addr_d    = StartAddr;
          ren_d     = 1'b1;
          rem_d     = (Length == '0) ? FullCount : CntW'(Length);
          div_lat_d = ClkDiv;
`ifdef SPI_TX_CRC16_EN
          crc_d     = '0;
          crc_en_d  = AppendCrc;
`endif
        end
      end

      StFetch: state_d = StLoad;

      StLoad: begin
        state_d = StShift;
        shift_d = BufReadData[6:0];
        mosi_d  = BufReadData[7];
        bit_d   = 4'd7;
        sck_d   = 1'b0;
        div_d   = div_lat_q;
        tail_d  = 1'b0;
        rem_d   = rem_q - CntW'(1);
        if (rem_q > CntW'(1)) begin
          ren_d  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      StShift, StCrc: begin
        if (tail_q) begin
          state_d = StDone;
          mosi_d  = 1'b1;
          tail_d  = 1'b0;
        end else if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = div_lat_q;
          if (!sck_q) begin
            sck_d = 1'b1;
`ifdef SPI_TX_CRC16_EN
            // Fold each payload bit into the CRC as it is clocked out.
            if (state_q == StShift) begin
              crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ mosi_q) ? 16'h1021 : 16'h0000);
            end
`endif
          end else begin
            sck_d = 1'b0;
            if (bit_q != 4'd0) begin
              bit_d = bit_q - 4'd1;
`ifdef SPI_TX_CRC16_EN
              if (state_q == StCrc) begin
                crc_d  = {crc_q[14:0], 1'b0};
                mosi_d = crc_q[14];
              end else begin
                shift_d = {shift_q[5:0], 1'b0};
                mosi_d  = shift_q[6];
              end
`else
              shift_d = {shift_q[5:0], 1'b0};
              mosi_d  = shift_q[6];
`endif
            end else if (rem_q != '0) begin
              // Byte boundary: next byte's MSB goes out on this same SCK fall.
              shift_d = hold_q[6:0];
              mosi_d  = hold_q[7];
              bit_d   = 4'd7;
              rem_d   = rem_q - CntW'(1);
              if (rem_q > CntW'(1)) begin
                ren_d  = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
              end
            end
`ifdef SPI_TX_CRC16_EN
            else if (state_q == StShift && crc_en_q) begin
              state_d = StCrc;
              mosi_d  = crc_q[15];
              bit_d   = 4'd15;
            end
`endif
            else begin
              tail_d = 1'b1;
            end
          end
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      ren_q     <= 1'b0;
      ren_dly_q <= 1'b0;
      rem_q     <= '0;
      div_lat_q <= '0;
      div_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      shift_q   <= '0;
      bit_q     <= '0;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ren_q     <= ren_d;
      ren_dly_q <= ren_q;
      rem_q     <= rem_d;
      div_lat_q <= div_lat_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      tail_q    <= tail_d;
    end
  end

`ifdef SPI_TX_CRC16_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      crc_q    <= '0;
      crc_en_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_en_q <= crc_en_d;
    end
  end
`endif

  // Capture every returning read; the shifter only consumes it at a byte boundary.
  always_ff @(posedge Clk) begin
    if (ren_dly_q) begin
      hold_q <= BufReadData;
    end
  end

  assign Busy          = (state_q == StFetch) || (state_q == StLoad) ||
                         (state_q == StShift) || (state_q == StCrc);
  assign Done          = (state_q == StDone);
  assign BufReadEnable = ren_q;
  assign BufReadAddr   = addr_q;
  assign SpiSck        = sck_q;
  assign SpiMosi       = mosi_q;

endmodule

// File: tb/tb_spi_buffer_tx.sv
// Testbench for spi_buffer_tx: a buffer model feeds the read port; expected
// read addresses and MOSI bits are queued at launch and popped as the DUT
// issues reads and SCK rises.
module tb_spi_buffer_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] start_addr;
  logic [10:0] length;
  logic [7:0]  clk_div;
`ifdef SPI_TX_CRC16_EN
  logic        append_crc;
`endif
  logic        busy, done, ren, sck, mosi;
  logic [10:0] raddr;
  logic [7:0]  rdata;

  logic [7:0]  mem [2048];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [10:0] addrq[$];
  logic        bitq[$];

  int busy_cnt, ren_cnt, rise_cnt, done_cnt;
  int first_busy, first_ren, first_rise, last_rise, done_cyc;
  int exp_period;
  int t_start;
  logic done_mosi, done_sck, done_busy;
  logic sck_prev, mosi_prev;
  logic [10:0] exp_a;
  logic        exp_b;

  spi_buffer_tx dut (
    .Clk          (clk),
    .Reset        (rst),
    .Start        (start),
    .StartAddr    (start_addr),
    .Length       (length),
    .ClkDiv       (clk_div),
`ifdef SPI_TX_CRC16_EN
    .AppendCrc    (append_crc),
`endif
    .Busy         (busy),
    .Done         (done),
    .BufReadEnable(ren),
    .BufReadAddr  (raddr),
    .BufReadData  (rdata),
    .SpiSck       (sck),
    .SpiMosi      (mosi)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Block RAM model, one-cycle read latency.
  always @(posedge clk) if (ren === 1'b1) rdata <= mem[raddr];

  // Monitor and scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      busy_cnt++;
      if (first_busy < 0) first_busy = cyc;
    end
    if (ren === 1'b1) begin
      ren_cnt++;
      if (first_ren < 0) first_ren = cyc;
      checks++;
      if (addrq.size() == 0) begin
        errors++;
        $display("FAIL read_addr: got unexpected read at %h, required no read", raddr);
      end else begin
        exp_a = addrq.pop_front();
        if (raddr !== exp_a) begin
          errors++;
          $display("FAIL read_addr: got %h, required %h", raddr, exp_a);
        end
      end
    end
    if (sck === 1'b1 && sck_prev === 1'b0) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = cyc;
      else begin
        checks++;
        if (cyc - last_rise != exp_period) begin
          errors++;
          $display("FAIL sck_period: got %0d, required %0d", cyc - last_rise, exp_period);
        end
      end
      last_rise = cyc;
      checks++;
      if (bitq.size() == 0) begin
        errors++;
        $display("FAIL mosi_bit: got extra SCK rise (mosi %b), required none", mosi);
      end else begin
        exp_b = bitq.pop_front();
        if (mosi !== exp_b) begin
          errors++;
          $display("FAIL mosi_bit: got %b on rise %0d, required %b", mosi, rise_cnt, exp_b);
        end
      end
    end
    if (mosi !== mosi_prev) begin
      checks++;
      if (sck !== 1'b0) begin
        errors++;
        $display("FAIL mosi_change: got change with sck %b, required sck 0", sck);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc  = cyc;
      done_mosi = mosi;
      done_sck  = sck;
      done_busy = busy;
    end
    sck_prev  = sck;
    mosi_prev = mosi;
  end

  task automatic launch(input logic [10:0] a, input logic [10:0] l, input logic [7:0] d,
                        input bit crc);
    int n;
    logic [10:0] ad;
    logic [15:0] crc_exp;
    crc_exp = 16'h7FA1;
    n = (l == 11'd0) ? 2048 : int'(l);
    bitq.delete();
    addrq.delete();
    busy_cnt = 0; ren_cnt = 0; rise_cnt = 0; done_cnt = 0;
    first_busy = -1; first_ren = -1; first_rise = -1; last_rise = 0; done_cyc = -1;
    exp_period = 2 * (int'(d) + 1);
    for (int i = 0; i < n; i++) begin
      ad = a + i[10:0];
      addrq.push_back(ad);
      for (int b = 7; b >= 0; b--) bitq.push_back(mem[ad][b]);
    end
    if (crc) for (int b = 15; b >= 0; b--) bitq.push_back(crc_exp[b]);
    @(negedge clk);
    start_addr = a;
    length     = l;
    clk_div    = d;
`ifdef SPI_TX_CRC16_EN
    append_crc = crc;
`endif
    start      = 1'b1;
    t_start    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; clk_div = '0;
`ifdef SPI_TX_CRC16_EN
    append_crc = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    checks++; if (ren !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b, required 0", ren); end
    checks++; if (raddr !== 11'd0) begin errors++; $display("FAIL rst_addr: got %h, required 0", raddr); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL rst_sck: got %b, required 0", sck); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL rst_mosi: got %b, required 1", mosi); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    bit ok;
    mem[11'h010] = 8'hA5;
    launch(11'h010, 11'd1, 8'd0, 1'b0);
    wait_done(200, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL single_done_seen: got 0, required 1"); end
    checks++; if (busy_cnt != 19) begin errors++; $display("FAIL single_busy_len: got %0d, required 19", busy_cnt); end
    checks++; if (first_busy - t_start != 1) begin errors++; $display("FAIL single_busy_lat: got %0d, required 1", first_busy - t_start); end
    checks++; if (first_ren - t_start != 1) begin errors++; $display("FAIL single_ren_lat: got %0d, required 1", first_ren - t_start); end
    checks++; if (ren_cnt != 1) begin errors++; $display("FAIL single_reads: got %0d, required 1", ren_cnt); end
    checks++; if (first_rise - t_start != 4) begin errors++; $display("FAIL single_rise_lat: got %0d, required 4", first_rise - t_start); end
    checks++; if (rise_cnt != 8) begin errors++; $display("FAIL single_rises: got %0d, required 8", rise_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d, required 1", done_cnt); end
    checks++; if (done_cyc - t_start != 20) begin errors++; $display("FAIL single_done_lat: got %0d, required 20", done_cyc - t_start); end
    checks++; if (done_mosi !== 1'b1 || done_sck !== 1'b0 || done_busy !== 1'b0) begin
      errors++; $display("FAIL single_done_lines: got mosi %b sck %b busy %b, required 1 0 0", done_mosi, done_sck, done_busy);
    end
    checks++; if (bitq.size() != 0) begin errors++; $display("FAIL single_bits_left: got %0d, required 0", bitq.size()); end
  endtask

  task automatic test_wrap_gapless();
    bit ok;
    launch(11'h7FE, 11'd4, 8'd2, 1'b0);
    wait_done(500, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_done_seen: got 0, required 1"); end
    checks++; if (rise_cnt != 32) begin errors++; $display("FAIL wrap_rises: got %0d, required 32", rise_cnt); end
    checks++; if (ren_cnt != 4) begin errors++; $display("FAIL wrap_reads: got %0d, required 4", ren_cnt); end
    checks++; if (addrq.size() != 0 || bitq.size() != 0) begin
      errors++; $display("FAIL wrap_left: got %0d addrs %0d bits, required 0 0", addrq.size(), bitq.size());
    end
  endtask

  task automatic test_full_buffer();
    bit ok;
    launch(11'h123, 11'd0, 8'd0, 1'b0);
    wait_done(40000, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL full_done_seen: got 0, required 1"); end
    checks++; if (ren_cnt != 2048) begin errors++; $display("FAIL full_reads: got %0d, required 2048", ren_cnt); end
    checks++; if (rise_cnt != 16384) begin errors++; $display("FAIL full_rises: got %0d, required 16384", rise_cnt); end
    checks++; if (bitq.size() != 0) begin errors++; $display("FAIL full_bits_left: got %0d, required 0", bitq.size()); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    bit hit;
    launch(11'h200, 11'd4, 8'd1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rise_cnt >= 13) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin errors++; $display("FAIL abort_reach: got %0d rises, required 13", rise_cnt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    checks++; if (sck !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b, required 0", sck); end
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL abort_mosi: got %b, required 1", mosi); end
    checks++; if (ren !== 1'b0 || raddr !== 11'd0) begin errors++; $display("FAIL abort_read: got ren %b addr %h, required 0 0", ren, raddr); end
    bitq.delete();
    addrq.delete();
    repeat (40) @(negedge clk);
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d, required 0", done_cnt); end
    launch(11'h300, 11'd2, 8'd0, 1'b0);
    wait_done(200, ok);
    @(negedge clk);
    checks++; if (!ok || done_cnt != 1) begin errors++; $display("FAIL after_abort_done: got %0d, required 1", done_cnt); end
    checks++; if (rise_cnt != 16 || ren_cnt != 2) begin
      errors++; $display("FAIL after_abort_counts: got %0d rises %0d reads, required 16 2", rise_cnt, ren_cnt);
    end
    checks++; if (bitq.size() != 0) begin errors++; $display("FAIL after_abort_bits: got %0d left, required 0", bitq.size()); end
  endtask

  task automatic test_start_ignored();
    bit ok;
    launch(11'h050, 11'd2, 8'd1, 1'b0);
    repeat (10) @(negedge clk);
    start_addr = 11'h400; length = 11'd7; clk_div = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy_mid: got %b, required 1", busy); end
    wait_done(500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_done_seen: got 0, required 1"); end
    start_addr = 11'h600; length = 11'd3; clk_div = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0 || ren !== 1'b0) begin
      errors++; $display("FAIL ign_on_done: got busy %b ren %b, required 0 0", busy, ren);
    end
    repeat (10) @(negedge clk);
    checks++; if (busy_cnt != 67) begin errors++; $display("FAIL ign_busy_len: got %0d, required 67", busy_cnt); end
    checks++; if (ren_cnt != 2 || rise_cnt != 16) begin
      errors++; $display("FAIL ign_counts: got %0d reads %0d rises, required 2 16", ren_cnt, rise_cnt);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d, required 1", done_cnt); end
    checks++; if (bitq.size() != 0) begin errors++; $display("FAIL ign_bits_left: got %0d, required 0", bitq.size()); end
  endtask

`ifdef SPI_TX_CRC16_EN
  task automatic test_crc16();
    bit ok;
    for (int i = 0; i < 512; i++) mem[i] = 8'hFF;
    launch(11'h000, 11'd512, 8'd0, 1'b1);
    wait_done(20000, ok);
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL crc_done_seen: got 0, required 1"); end
    checks++; if (rise_cnt != 4112) begin errors++; $display("FAIL crc_rises: got %0d, required 4112", rise_cnt); end
    checks++; if (ren_cnt != 512) begin errors++; $display("FAIL crc_reads: got %0d, required 512", ren_cnt); end
    checks++; if (bitq.size() != 0) begin errors++; $display("FAIL crc_bits_left: got %0d, required 0", bitq.size()); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    busy_cnt = 0; ren_cnt = 0; rise_cnt = 0; done_cnt = 0;
    first_busy = -1; first_ren = -1; first_rise = -1; last_rise = 0; done_cyc = -1;
    exp_period = 2;
    test_reset();
    test_single_byte();
    test_wrap_gapless();
    test_full_buffer();
    test_reset_abort();
    test_start_ignored();
`ifdef SPI_TX_CRC16_EN
    test_crc16();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
